wb_arbiter: RTL

Writeback stage that owns the register file's single write port (`we3`/`a3`/`wd3`). It merges in-order pipeline results with out-of-band results from the multicycle load unit. Pipeline writes always win the port; load-unit results wait in a small queue and drain on idle slots. The block exports a pending-write mask that the hazard unit uses to stall readers.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_queue.sv | 106 ++++++++++
 rtl/wb_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the queued-writeback entry type for the writeback arbiter.
package wb_pkg;

   localparam int unsigned WB_XLEN = 32;
   localparam int unsigned WB_AW   = 5;

   // One out-of-band load result waiting for a free regfile write slot.
   // The field widths follow WB_XLEN/WB_AW, so any width override has to be
   // made here as well as on the module parameters.
   typedef struct packed {
      logic                 live;
      logic [WB_AW-1:0]     rd;
      logic [WB_XLEN-1:0]   wd;
   } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular buffer of load-unit results. Each entry can be killed by rd
// (squash), and the buffer reports the set of registers with a live entry.
module wb_queue
   import wb_pkg::*;
#(
   parameter int unsigned XLEN  = WB_XLEN,
   parameter int unsigned AW    = WB_AW,
   parameter int unsigned DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push_i,
   input  logic [AW-1:0]               push_rd_i,
   input  logic [XLEN-1:0]             push_wd_i,
   input  logic                        pop_i,
   input  logic                        squash_en_i,
   input  logic [AW-1:0]               squash_rd_i,
   output wb_entry_t                   head_o,
   output logic [$clog2(DEPTH):0]      count_o,
   output logic [(1<<AW)-1:0]          pend_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [(1<<AW)-1:0] pend_s;

   // Next-state: squash matching entries, retire the head, append the new entry.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (squash_en_i && (mem_q[i].rd == squash_rd_i)) begin
            mem_d[i].live = 1'b0;
         end else begin
            mem_d[i].live = mem_q[i].live;
         end
      end

      // A retired slot must not keep contributing to the pending mask.
      if (pop_i) begin
         mem_d[head_q].live = 1'b0;
         head_d             = head_q + PTR_ONE;
      end else begin
         head_d = head_q;
      end

      // Push never lands on the head slot being popped: push needs count<DEPTH
      // and pop needs count>0, so tail==head only when one of them is idle.
      if (push_i) begin
         mem_d[tail_q].live = 1'b1;
         mem_d[tail_q].rd   = push_rd_i;
         mem_d[tail_q].wd   = push_wd_i;
         tail_d             = tail_q + PTR_ONE;
      end else begin
         tail_d = tail_q;
      end

      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Queue state registers; reset kills every entry without writing it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Pending mask: OR of live entries by destination; r0 is never pending.
   always_comb begin
      pend_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_s[mem_q[i].rd] = pend_s[mem_q[i].rd] | mem_q[i].live;
      end
      pend_s[0] = 1'b0;
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;
   assign pend_o  = pend_s;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the regfile write port. Pipeline results always win;
// load-unit results queue up and drain in slots the pipeline leaves idle.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned XLEN  = WB_XLEN,
   parameter int unsigned AW    = WB_AW,
   parameter int unsigned DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        pipe_we,
   input  logic [AW-1:0]               pipe_rd,
   input  logic [XLEN-1:0]             pipe_wd,
   input  logic                        lu_valid,
   output logic                        lu_ready,
   input  logic [AW-1:0]               lu_rd,
   input  logic [XLEN-1:0]             lu_wd,
   output logic                        we3,
   output logic [AW-1:0]               a3,
   output logic [XLEN-1:0]             wd3,
   output logic [(1<<AW)-1:0]          pend,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [AW-1:0] RD_ZERO  = {AW{1'b0}};

   wb_entry_t        head_s;
   logic [CW-1:0]    count_s;
   logic             issue_pipe_s;
   logic             head_avail_s;
   logic             head_live_s;
   logic             pop_s;
   logic             push_hs_s;
   logic             push_keep_s;
   logic             we3_q, we3_d;
   logic [AW-1:0]    a3_q, a3_d;
   logic [XLEN-1:0]  wd3_q, wd3_d;

   // A pipeline write to r0 is not a write at all, so that slot is free for the queue.
   assign issue_pipe_s = pipe_we && (pipe_rd != RD_ZERO);
   assign head_avail_s = (count_s != {CW{1'b0}});
   assign head_live_s  = head_avail_s && head_s.live;
   // Dead heads leave regardless of the pipeline; live heads only in an idle slot.
   assign pop_s        = head_avail_s && (!head_s.live || !issue_pipe_s);

   assign lu_ready     = (count_s < CNT_FULL) && !reset;
   assign push_hs_s    = lu_valid && lu_ready;
   // r0 results and results the pipeline overwrites this cycle are accepted but dropped.
   assign push_keep_s  = push_hs_s && (lu_rd != RD_ZERO) &&
                         !(pipe_we && (pipe_rd == lu_rd));

   wb_queue #(
      .XLEN  (XLEN),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push_keep_s),
      .push_rd_i   (lu_rd),
      .push_wd_i   (lu_wd),
      .pop_i       (pop_s),
      .squash_en_i (issue_pipe_s),
      .squash_rd_i (pipe_rd),
      .head_o      (head_s),
      .count_o     (count_s),
      .pend_o      (pend)
   );

   // Issue mux: pipeline first, then a live queue head, otherwise no write.
   always_comb begin
      if (issue_pipe_s) begin
         we3_d = 1'b1;
         a3_d  = pipe_rd;
         wd3_d = pipe_wd;
      end else if (head_live_s) begin
         we3_d = 1'b1;
         a3_d  = head_s.rd;
         wd3_d = head_s.wd;
      end else begin
         we3_d = 1'b0;
         a3_d  = a3_q;
         wd3_d = wd3_q;
      end
   end

   // Registered regfile write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         we3_q <= 1'b0;
         a3_q  <= '0;
         wd3_q <= '0;
      end else begin
         we3_q <= we3_d;
         a3_q  <= a3_d;
         wd3_q <= wd3_d;
      end
   end

   assign we3   = we3_q;
   assign a3    = a3_q;
   assign wd3   = wd3_q;
   assign count = count_s;

endmodule
